// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative signed Booth multiplier / restoring divider producing Hi/Lo
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_t;

  state_t state, state_nx;

  // acc/q/m are shared: Booth {acc,q,q_m1} for MULT, {remainder,dividend/quotient,|divisor|} for DIV
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             q_m1;
  logic [WIDTH:0]   m;
  logic             a_neg;
  logic             b_neg;

  logic             last;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  logic [WIDTH:0]   booth_sum;
  logic [WIDTH:0]   booth_acc;
  logic [WIDTH-1:0] booth_q;
  logic             booth_qm1;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_diff;
  logic [WIDTH:0]   div_rem;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] quo_fix;
  logic [WIDTH-1:0] rem_fix;

  assign last  = (cnt == CNT_W'(1));
  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);

  // One Booth step; acc carries an extra sign bit so subtracting -2**(W-1) cannot overflow
  always_comb begin
    booth_sum = acc;
    case ({q[0], q_m1})
      2'b01:   booth_sum = acc + m;
      2'b10:   booth_sum = acc - m;
      default: booth_sum = acc;
    endcase
    {booth_acc, booth_q, booth_qm1} = {booth_sum[WIDTH], booth_sum, q};
  end

  // One restoring-division step on magnitudes, then sign correction for the final step
  always_comb begin
    rem_sh   = {acc[WIDTH-1:0], q[WIDTH-1]};
    rem_diff = rem_sh - m;
    if (rem_diff[WIDTH]) begin
      div_rem = rem_sh;
      div_q   = {q[WIDTH-2:0], 1'b0};
    end else begin
      div_rem = rem_diff;
      div_q   = {q[WIDTH-2:0], 1'b1};
    end
    quo_fix = (a_neg ^ b_neg) ? -div_q : div_q;
    rem_fix = a_neg ? -div_rem[WIDTH-1:0] : div_rem[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (!op)           state_nx = S_MULT;
          else if (b == '0)  state_nx = S_DONE;
          else               state_nx = S_DIV;
        end
      end
      S_MULT:  if (last) state_nx = S_DONE;
      S_DIV:   if (last) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // The last iteration loads hi/lo directly so partial results never reach the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      acc      <= '0;
      q        <= '0;
      q_m1     <= 1'b0;
      m        <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (!op) begin
              acc      <= '0;
              q        <= b;
              q_m1     <= 1'b0;
              m        <= {a[WIDTH-1], a};
              cnt      <= CNT_W'(WIDTH);
              div_zero <= 1'b0;
            end else if (b == '0) begin
              div_zero <= 1'b1;
            end else begin
              acc      <= '0;
              q        <= a_mag;
              m        <= {1'b0, b_mag};
              a_neg    <= a[WIDTH-1];
              b_neg    <= b[WIDTH-1];
              cnt      <= CNT_W'(WIDTH);
              div_zero <= 1'b0;
            end
          end
        end
        S_MULT: begin
          acc  <= booth_acc;
          q    <= booth_q;
          q_m1 <= booth_qm1;
          cnt  <= cnt - CNT_W'(1);
          if (last) begin
            hi <= booth_acc[WIDTH-1:0];
            lo <= booth_q;
          end
        end
        S_DIV: begin
          acc <= div_rem;
          q   <= div_q;
          cnt <= cnt - CNT_W'(1);
          if (last) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit with arithmetic reference model
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference model: accepts start when idle, predicts latency and results from plain arithmetic
  int          pend = 0;
  int          left = 0;
  int          lat_m = 0;
  logic [31:0] exp_hi = 0, exp_lo = 0, nxt_hi = 0, nxt_lo = 0;
  logic        exp_dz = 0, nxt_dz = 0;

  always @(negedge clk) begin
    bit     fin;
    longint sa, sb, p;
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_dz", div_zero, 0);
      pend = 0; exp_hi = 0; exp_lo = 0; exp_dz = 0;
    end else begin
      fin = 0;
      if (pend != 0) begin
        left--;
        if (left == lat_m - 1) exp_dz = nxt_dz;
        if (left == 0) begin
          fin = 1;
          exp_hi = nxt_hi;
          exp_lo = nxt_lo;
        end
      end
      chk("busy", busy, (pend != 0));
      chk("done", done, fin);
      chk("hi", hi, exp_hi);
      chk("lo", lo, exp_lo);
      chk("div_zero", div_zero, exp_dz);
      if (fin) begin
        pend = 0;
      end else if (pend == 0 && start) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        pend = 1;
        if (!op) begin
          p = sa * sb;
          nxt_hi = p[63:32]; nxt_lo = p[31:0]; nxt_dz = 0; lat_m = 33;
        end else if (b == 0) begin
          nxt_hi = exp_hi; nxt_lo = exp_lo; nxt_dz = 1; lat_m = 1;
        end else begin
          p = sa / sb;
          nxt_lo = p[31:0];
          p = sa % sb;
          nxt_hi = p[31:0];
          nxt_dz = 0; lat_m = 33;
        end
        left = lat_m;
      end
    end
  end

  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(posedge clk); #2;
    op = o; a = x; b = y; start = 1;
    @(posedge clk); #2;
    start = 0; a = $urandom; b = $urandom; op = 1'($urandom_range(0, 1));
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #2;
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          lat, ndone;
    logic [31:0] x, y, cap_hi, cap_lo;
    logic        o;
    clk = 0; reset = 1; start = 0; op = 0; a = 0; b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    @(posedge clk); #2 reset = 0;

    run_op(0, 32'd7, -32'sd3, lat);
    chk("mul7x-3_lat", lat, 33);
    chk("mul7x-3_hi", hi, 32'hFFFFFFFF);
    chk("mul7x-3_lo", lo, 32'hFFFFFFEB);

    run_op(1, -32'sd7, 32'd2, lat);
    chk("div-7/2_lat", lat, 33);
    chk("div-7/2_lo", lo, 32'hFFFFFFFD);
    chk("div-7/2_hi", hi, 32'hFFFFFFFF);
    chk("div-7/2_dz", div_zero, 0);

    run_op(1, 32'd100, 32'd7, lat);
    chk("div100/7_lo", lo, 32'd14);
    chk("div100/7_hi", hi, 32'd2);

    run_op(1, 32'h02469234, 32'h2000, lat);
    chk("div_prep_lo", lo, 32'h1234);
    chk("div_prep_hi", hi, 32'h1234);
    run_op(1, 32'd5, 32'd0, lat);
    chk("divzero_lat", lat, 1);
    chk("divzero_flag", div_zero, 1);
    chk("divzero_hi", hi, 32'h1234);
    chk("divzero_lo", lo, 32'h1234);

    run_op(0, 32'h80000000, 32'h80000000, lat);
    chk("mulmin_hi", hi, 32'h40000000);
    chk("mulmin_lo", lo, 32'h0);
    chk("mulmin_dz_clear", div_zero, 0);
    run_op(1, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("divovf_lo", lo, 32'h80000000);
    chk("divovf_hi", hi, 32'h0);

    // second start mid-MULT must be dropped
    @(posedge clk); #2;
    op = 0; a = 32'd6; b = 32'd7; start = 1;
    @(posedge clk); #2 start = 0;
    repeat (4) @(posedge clk);
    #2 op = 1; a = 32'd100; b = 32'd0; start = 1;
    @(posedge clk); #2 start = 0;
    ndone = 0; cap_hi = 0; cap_lo = 0;
    for (int i = 0; i < 45; i++) begin
      if (done) begin
        ndone++;
        cap_hi = hi; cap_lo = lo;
      end
      @(posedge clk); #2;
    end
    chk("ignore_ndone", ndone, 1);
    chk("ignore_lo", cap_lo, 32'd42);
    chk("ignore_hi", cap_hi, 32'd0);

    // reset in the middle of a DIV aborts it
    @(posedge clk); #2;
    op = 1; a = 32'd1000; b = 32'd3; start = 1;
    @(posedge clk); #2 start = 0;
    repeat (9) @(posedge clk);
    #2 reset = 1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_hi", hi, 0);
    chk("abort_lo", lo, 0);
    @(posedge clk); #2 reset = 0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) ndone++;
      @(posedge clk); #2;
    end
    chk("abort_no_done", ndone, 0);
    run_op(0, 32'd3, 32'd4, lat);
    chk("mul3x4_lo", lo, 32'd12);
    chk("mul3x4_hi", hi, 32'd0);

    for (int i = 0; i < 10; i++) begin
      o = 1'(i % 2);
      x = $urandom;
      y = $urandom_range(1, 1000);
      if (i % 3 == 0) y = -y;
      if (i == 5) y = 0;
      if (i == 8) y = $urandom;
      run_op(o, x, y, lat);
      chk("rand_lat", lat, (o && y == 0) ? 1 : 33);
    end

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
